// File: rtl/arbiter_pkg.sv
// Shared types for the four-requester round-robin arbiter.
package arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;

    typedef logic [1:0] idx_t;

    typedef enum logic [2:0] {
        IDLE,
        GNT0,
        GNT1,
        GNT2,
        GNT3
    } arb_state_t;

    // Map a requester index to the state that grants it.
    function automatic arb_state_t gnt_state(idx_t idx);
        arb_state_t st;
        case (idx)
            2'd0:    st = GNT0;
            2'd1:    st = GNT1;
            2'd2:    st = GNT2;
            default: st = GNT3;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin picker: rotate the requests so the start index
// lands on bit 0, take the lowest set bit, then rotate the index back.
module rr_pick
    import arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  idx_t               start,
    output logic               valid,
    output idx_t               winner
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    idx_t                 pos;

    // Doubling the vector turns the rotate into a plain part-select.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[start +: NUM_REQ];

    // Fixed-priority select on the rotated vector, lowest bit wins.
    always_comb begin
        pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pos = idx_t'(i);
            end
        end
    end

    // Un-rotate; the 2-bit add wraps modulo 4.
    assign valid  = |req;
    assign winner = start + pos;

endmodule

// File: rtl/arbiter.sv
// Four-requester round-robin arbiter with one-hot grants decoded from the
// state register. A grant is held until its requester drops, then passes
// directly to the next requester in rotating order.
module arbiter
    import arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req3,
    input  logic req2,
    input  logic req1,
    input  logic req0,
    output logic gnt3,
    output logic gnt2,
    output logic gnt1,
    output logic gnt0
);

    arb_state_t         state_q;
    idx_t               last_q;
    logic [NUM_REQ-1:0] req_vec;
    idx_t               search_start;
    logic               pick_valid;
    idx_t               pick_idx;

    assign req_vec      = {req3, req2, req1, req0};
    assign search_start = last_q + 2'd1;

    rr_pick u_rr_pick (
        .req    (req_vec),
        .start  (search_start),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    // State and last-grant pointer; in any GNTn state last_q equals n.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        state_q <= gnt_state(pick_idx);
                        last_q  <= pick_idx;
                    end
                end
                default: begin
                    // Owner still requesting: hold. Otherwise hand over with no idle gap.
                    if (!req_vec[last_q]) begin
                        if (pick_valid) begin
                            state_q <= gnt_state(pick_idx);
                            last_q  <= pick_idx;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Grants come straight from the state register, never from req.
    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);
    assign gnt2 = (state_q == GNT2);
    assign gnt3 = (state_q == GNT3);

endmodule

// File: tb/tb_arbiter.sv
// Directed bench for the round-robin arbiter with a behavioural model
// checked every cycle plus literal expectations at key points.
module tb_arbiter;

    logic clk;
    logic rst;
    logic req3, req2, req1, req0;
    logic gnt3, gnt2, gnt1, gnt0;

    int vectors;
    int miscompares;
    bit check_en;

    // Model: owner index (-1 when idle) and most recent grant index.
    int m_owner;
    int m_last;

    arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .req3 (req3),
        .req2 (req2),
        .req1 (req1),
        .req0 (req0),
        .gnt3 (gnt3),
        .gnt2 (gnt2),
        .gnt1 (gnt1),
        .gnt0 (gnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] owner_vec(int owner);
        logic [3:0] v;
        v = 4'b0000;
        if (owner >= 0) v[owner] = 1'b1;
        return v;
    endfunction

    // Owner keeps the resource while requesting; otherwise scan last+1..last+4.
    function automatic int model_next(int owner, int last, logic [3:0] r);
        if (owner >= 0 && r[owner]) return owner;
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        m_owner = -1;
        m_last  = 3;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_owner = -1;
                m_last  = 3;
            end else begin
                m_owner = model_next(m_owner, m_last, {req3, req2, req1, req0});
                if (m_owner >= 0) m_last = m_owner;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                vectors++;
                if ({gnt3, gnt2, gnt1, gnt0} !== owner_vec(m_owner)) begin
                    miscompares++;
                    $display("FAIL model_cmp t=%0t: gnt=%b expected=%b", $time,
                             {gnt3, gnt2, gnt1, gnt0}, owner_vec(m_owner));
                end
                vectors++;
                if ($countones({gnt3, gnt2, gnt1, gnt0}) > 1) begin
                    miscompares++;
                    $display("FAIL onehot t=%0t: gnt=%b expected at most one bit",
                             $time, {gnt3, gnt2, gnt1, gnt0});
                end
            end
        end
    end

    task automatic step(input logic r_rst, input logic [3:0] r);
        rst = r_rst;
        {req3, req2, req1, req0} = r;
        @(posedge clk);
        #1;
    endtask

    // Literal expectation: checks both the DUT and the model.
    task automatic expect_gnt(input string name, input logic [3:0] exp);
        vectors++;
        if ({gnt3, gnt2, gnt1, gnt0} !== exp) begin
            miscompares++;
            $display("FAIL %s: gnt=%b expected=%b", name, {gnt3, gnt2, gnt1, gnt0}, exp);
        end
        vectors++;
        if (owner_vec(m_owner) !== exp) begin
            miscompares++;
            $display("FAIL %s_model: model=%b expected=%b", name, owner_vec(m_owner), exp);
        end
    endtask

    task automatic step_chk(input string name, input logic r_rst, input logic [3:0] r,
                            input logic [3:0] exp);
        step(r_rst, r);
        expect_gnt(name, exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        check_en    = 1'b0;
        rst         = 1'b1;
        {req3, req2, req1, req0} = 4'b0000;

        // Reset held with random requests.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'($urandom_range(0, 15)));
            check_en = 1'b1;
            expect_gnt("reset_hold", 4'b0000);
        end
        step_chk("first_gnt0", 1'b0, 4'b0001, 4'b0001);
        step_chk("rel0", 1'b0, 4'b0000, 4'b0000);

        // Single-cycle pulse after reset.
        step_chk("pulse_rst", 1'b1, 4'b0000, 4'b0000);
        step_chk("pulse_gnt", 1'b0, 4'b0001, 4'b0001);
        step_chk("pulse_drop", 1'b0, 4'b0000, 4'b0000);
        step_chk("pulse_idle", 1'b0, 4'b0000, 4'b0000);

        // Rotation chain with last pointing at 0.
        step_chk("rot_gnt1", 1'b0, 4'b0011, 4'b0010);
        step_chk("rot_gnt2", 1'b0, 4'b0101, 4'b0100);
        step_chk("rot_gnt3", 1'b0, 4'b1001, 4'b1000);
        step_chk("rot_gnt0", 1'b0, 4'b0001, 4'b0001);
        step_chk("rot_idle", 1'b0, 4'b0000, 4'b0000);

        // Hold gnt2 while everyone else waits.
        step_chk("hold_gnt2", 1'b0, 4'b0100, 4'b0100);
        for (int i = 0; i < 10; i++) step_chk("hold_keep", 1'b0, 4'b1111, 4'b0100);
        step_chk("hold_gnt3", 1'b0, 4'b1011, 4'b1000);
        step_chk("hold_gnt3b", 1'b0, 4'b1011, 4'b1000);
        step_chk("hold_gnt0", 1'b0, 4'b0011, 4'b0001);
        step_chk("hold_gnt1", 1'b0, 4'b0010, 4'b0010);
        step_chk("hold_gnt1b", 1'b0, 4'b0010, 4'b0010);
        step_chk("hold_idle", 1'b0, 4'b0000, 4'b0000);

        // All four requesting, each dropping one cycle after its grant.
        step_chk("all_rst", 1'b1, 4'b0000, 4'b0000);
        step_chk("all_g0", 1'b0, 4'b1111, 4'b0001);
        step_chk("all_g1", 1'b0, 4'b1110, 4'b0010);
        step_chk("all_g2", 1'b0, 4'b1101, 4'b0100);
        step_chk("all_g3", 1'b0, 4'b1011, 4'b1000);
        step_chk("all_g0b", 1'b0, 4'b0111, 4'b0001);
        step_chk("all_idle", 1'b0, 4'b0000, 4'b0000);

        // Reset during gnt3 restores the pointer.
        step_chk("mid_gnt3", 1'b0, 4'b1000, 4'b1000);
        step_chk("mid_rst", 1'b1, 4'b1010, 4'b0000);
        step_chk("mid_gnt1", 1'b0, 4'b1010, 4'b0010);

        // Sole requester is re-granted after its own release.
        step_chk("sole_rel", 1'b0, 4'b0000, 4'b0000);
        step_chk("sole_regnt", 1'b0, 4'b0010, 4'b0010);
        step_chk("sole_idle", 1'b0, 4'b0000, 4'b0000);

        @(negedge clk);
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
